react_timer: RTL
================

Name: react_timer

Overview:
- Reaction-time measurement block for the reflex game. It runs an up-counting decimal millisecond timer from the stimulus instant (`start`, driven by the countdown's zero) until the player's button (`stop`).
- Presents the result as packed BCD digits for the 7-segment driver.
- Flags a foul press before the stimulus, and saturates with an overflow flag when the player never responds.

Parameters:
- TICK_DIV, 100_000, clock cycles per count unit (1 ms at 100 MHz); minimum 2.
- DIGITS, 4, number of BCD decades in the result (max displayable = 10^DIGITS - 1).

Ports:
- ck  input  1  system clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- clear  input  1  synchronous return to IDLE, count zeroed
- arm  input  1  single-cycle pulse: prepare a new measurement
- start  input  1  single-cycle pulse: stimulus shown, begin counting
- stop  input  1  single-cycle, pre-debounced button pulse
- bcd  output  4*DIGITS  result, digit 0 in [3:0], registered
- armed  output  1  high in ARMED
- running  output  1  high in RUN
- done  output  1  high in DONE (valid result)
- foul  output  1  high in FOUL
- overflow  output  1  high in OVF
- best_bcd  output  4*DIGITS  best (minimum) valid result; see Optional Feature

Behaviour:
- Reset values:
  - State IDLE.
  - bcd = 0, prescaler = 0.
  - All flags = 0.
  - best_bcd = all 9s.
- States and transitions:
  - IDLE: arm -> ARMED (bcd := 0).
  - ARMED: stop -> FOUL. Otherwise start -> RUN (prescaler := 0). stop with start in the same cycle -> FOUL.
  - RUN: the prescaler counts 0..TICK_DIV-1 and ticks on TICK_DIV-1, then wraps to 0. Each tick increments bcd by 1 as a decimal ripple: digit 9 -> 0 with carry.
  - RUN, stop -> DONE with bcd frozen. If stop coincides with a tick, the tick's increment is included.
  - RUN, tick while bcd is all 9s -> OVF. bcd holds at all 9s with no wrap.
  - DONE / FOUL / OVF: hold bcd. arm -> ARMED (bcd := 0). start and stop are ignored.
- Priority: clear > arm > stop > start. clear in any state -> IDLE, bcd := 0, prescaler := 0; best_bcd is unaffected.
- Latency:
  - First increment occurs exactly TICK_DIV cycles after the start cycle.
  - Flags reflect the new state on the cycle after the causing input.
- Inputs in non-listed states are ignored: start in IDLE/RUN, stop in IDLE, arm in RUN/ARMED.
- Async reset mid-RUN aborts immediately to the reset values.
- The flags are mutually exclusive; at most one is high.

Optional Feature:
- Macro: REACT_BEST_EN.
- Defined:
  - On each RUN -> DONE transition, if the frozen result < best_bcd (decimal compare, most-significant digit first), best_bcd := result.
  - FOUL and OVF never update best_bcd.
  - Only reset restores all 9s.
- Undefined: best_bcd is constant all 9s and no compare logic is built.

Decomposition:
- Package react_pkg:
  - State encoding typedef: IDLE, ARMED, RUN, DONE, FOUL, OVF.
  - BCD_W = 4.
  - Digit constant NINE = 4'd9.
- Sub-module bcd_digit: one decade with inputs inc, clr and carry_in; outputs digit, carry_out and is_nine.
  - Instantiate DIGITS times in a ripple chain.
  - The all-9s saturation detect is the AND of is_nine across the chain.

Test Plan (TICK_DIV=4, DIGITS=4):
- Normal run: arm, start, stop 4*123 cycles after start -> done=1, bcd=16'h0123, running=0 the next cycle.
- Foul press: arm, stop before any start -> foul=1, bcd=0; a later start is ignored and state stays FOUL.
- Coincident inputs:
  - start and stop in the same cycle while ARMED -> foul=1.
  - stop on the exact tick cycle after 9 ticks -> bcd=16'h0010 (tick counted, carry correct).
- Saturation: arm, start, no stop for 4*10000 cycles -> overflow=1, bcd=16'h9999 held for 100 further cycles.
- Clear/reset mid-run: clear during RUN at bcd=0x0042 -> IDLE, bcd=0. Async reset pulse mid-RUN -> all outputs 0 immediately; best_bcd=16'h9999.
- REACT_BEST_EN: results 0x0250, then 0x0180, then 0x0300 -> best_bcd=0x0250, 0x0180, 0x0180. A FOUL in between leaves 0x0180.

Source files
------------

// File: rtl/react_pkg.sv
// Shared definitions for the reaction-time measurement block.
// Holds the FSM state encoding and the BCD digit constants used by
// react_timer and its decade counter.
package react_pkg;

    // Measurement FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        FOUL  = 3'd4,
        OVF   = 3'd5
    } state_e;

    // Width of one BCD decade
    localparam int BCD_W = 4;

    // Largest value a decade holds before it wraps
    localparam logic [BCD_W-1:0] NINE = 4'd9;

endpackage : react_pkg

// File: rtl/bcd_digit.sv
// One BCD decade of the reaction-time counter.
// The decade advances when the chain-wide increment enable is high and
// every lower decade is at nine (carry_in). It wraps 9 -> 0 and passes
// the carry upward. clr zeroes the decade synchronously.
module bcd_digit
    import react_pkg::*;
(
    input  logic             ck,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             carry_in,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out,
    output logic             is_nine
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    assign is_nine   = (digit_q == NINE);
    assign carry_out = carry_in & is_nine;
    assign digit     = digit_q;

    // Next decade value: clear, ripple increment with wrap, or hold
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc && carry_in) begin
            if (is_nine) begin
                digit_d = 4'd0;
            end else begin
                digit_d = digit_q + 4'd1;
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Decade register
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule : bcd_digit

// File: rtl/react_timer.sv
// Reaction-time measurement block for the reflex game.
// Counts milliseconds in BCD from the stimulus (start) to the player's
// button (stop), flags presses before the stimulus (FOUL) and saturates
// at all nines when the player never answers (OVF).
// Optional build macro REACT_BEST_EN: keep the best (smallest) valid
// result on best_bcd; without it best_bcd is constant all nines.
module react_timer
    import react_pkg::*;
#(
    parameter int TICK_DIV = 100_000,
    parameter int DIGITS   = 4
) (
    input  logic                  ck,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  arm,
    input  logic                  start,
    input  logic                  stop,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  armed,
    output logic                  running,
    output logic                  done,
    output logic                  foul,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   best_bcd
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINE = {DIGITS{NINE}};

    state_e            state_q;
    state_e            state_d;
    logic [PW-1:0]     prescaler_q;
    logic [PW-1:0]     prescaler_d;
    logic              tick_s;
    logic              inc_en_s;
    logic              digit_clr_s;
    logic              all_nine_s;
    logic [DIGITS:0]   carry_s;
    logic [DIGITS-1:0] is_nine_s;
    logic [4*DIGITS-1:0] bcd_s;

    logic armed_q;
    logic running_q;
    logic done_q;
    logic foul_q;
    logic overflow_q;

    // The lowest decade always sees a carry; higher decades ripple.
    assign carry_s[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            bcd_digit u_digit (
                .ck        (ck),
                .reset     (reset),
                .clr       (digit_clr_s),
                .inc       (inc_en_s),
                .carry_in  (carry_s[gi]),
                .digit     (bcd_s[gi*4 +: 4]),
                .carry_out (carry_s[gi+1]),
                .is_nine   (is_nine_s[gi])
            );
        end
    endgenerate

    // Saturation detect: every decade at nine
    assign all_nine_s = &is_nine_s;

    // A tick is the last prescaler cycle of each count unit while running
    assign tick_s = (state_q == RUN) && (prescaler_q == PS_MAX);

    // Next-state logic with clear > arm > stop > start priority
    always_comb begin
        state_d     = state_q;
        digit_clr_s = 1'b0;
        inc_en_s    = 1'b0;
        if (clear) begin
            state_d     = IDLE;
            digit_clr_s = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d     = ARMED;
                        digit_clr_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ARMED: begin
                    if (stop) begin
                        state_d = FOUL;
                    end else if (start) begin
                        state_d = RUN;
                    end else begin
                        state_d = ARMED;
                    end
                end
                RUN: begin
                    // Never step past all nines; a stop on a tick keeps the tick
                    inc_en_s = tick_s & ~all_nine_s;
                    if (stop) begin
                        state_d = DONE;
                    end else if (tick_s && carry_s[DIGITS]) begin
                        state_d = OVF;
                    end else begin
                        state_d = RUN;
                    end
                end
                DONE, FOUL, OVF: begin
                    if (arm) begin
                        state_d     = ARMED;
                        digit_clr_s = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    digit_clr_s = 1'b1;
                end
            endcase
        end
    end

    // Prescaler: counts only in RUN, zero everywhere else so RUN starts at 0
    always_comb begin
        prescaler_d = prescaler_q;
        if (clear) begin
            prescaler_d = '0;
        end else if (state_q == RUN) begin
            if (tick_s) begin
                prescaler_d = '0;
            end else begin
                prescaler_d = prescaler_q + PW'(1'b1);
            end
        end else begin
            prescaler_d = '0;
        end
    end

    // State and prescaler registers
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prescaler_q <= '0;
        end else begin
            state_q     <= state_d;
            prescaler_q <= prescaler_d;
        end
    end

    // Registered status flags decoded from the next state
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            armed_q    <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            foul_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            armed_q    <= (state_d == ARMED);
            running_q  <= (state_d == RUN);
            done_q     <= (state_d == DONE);
            foul_q     <= (state_d == FOUL);
            overflow_q <= (state_d == OVF);
        end
    end

    assign bcd      = bcd_s;
    assign armed    = armed_q;
    assign running  = running_q;
    assign done     = done_q;
    assign foul     = foul_q;
    assign overflow = overflow_q;

`ifdef REACT_BEST_EN
    logic                upd_q;
    logic [4*DIGITS-1:0] best_q;

    // Decimal compare, most-significant decade first
    function automatic logic bcd_less(input logic [4*DIGITS-1:0] a,
                                      input logic [4*DIGITS-1:0] b);
        logic decided;
        logic lt;
        decided = 1'b0;
        lt      = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                decided = 1'b1;
                lt      = (a[i*4 +: 4] < b[i*4 +: 4]);
            end else begin
                decided = decided;
            end
        end
        return lt;
    endfunction

    // Best-result tracker: the result is frozen in the digit registers
    // one cycle after RUN -> DONE, so compare then.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            upd_q  <= 1'b0;
            best_q <= ALL_NINE;
        end else begin
            upd_q <= (state_q == RUN) && (state_d == DONE);
            if (upd_q && bcd_less(bcd_s, best_q)) begin
                best_q <= bcd_s;
            end else begin
                best_q <= best_q;
            end
        end
    end

    assign best_bcd = best_q;
`else
    assign best_bcd = ALL_NINE;
`endif

endmodule : react_timer
